fir_tdm: RTL and testbench
==========================

FIR_TDM -- requirements
Module: fir_tdm

Interface
REQ-001 SHALL have parameter N, default 16: signed sample and coefficient width.
REQ-002 SHALL have parameter TAPS, default 8: filter length, range 2..64.
REQ-003 SHALL have parameter CHANNELS, default 2: independent interleaved channels, range 1..16.
REQ-004 SHALL have parameter SHIFT, default 0: arithmetic right shift applied to the accumulator before output.
REQ-005 SHALL derive localparam ACC_W = 2*N + clog2(TAPS) and CW = max(1, clog2(CHANNELS)).
REQ-006 clk  in  1  the single clock; all state changes on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 ena  in  1  global enable; low freezes all state.
REQ-009 coef_we  in  1  coefficient write strobe.
REQ-010 coef_addr  in  clog2(TAPS)  tap index k.
REQ-011 coef_data  in  N  signed coefficient b[k].
REQ-012 x_in  in  N  signed input sample.
REQ-013 x_chan  in  CW  channel of x_in.
REQ-014 x_valid  in  1  sample offered.
REQ-015 x_ready  out  1  block can accept a sample.
REQ-016 y_out  out  N  signed filtered sample.
REQ-017 y_chan  out  CW  channel of y_out.
REQ-018 y_valid  out  1  one-cycle pulse: y_out/y_chan valid.

Function
REQ-019 SHALL compute, per channel c, y[n] = sat_N((sum k=0..TAPS-1 of b[k]*x_c[n-k]) >>> SHIFT), using signed two's-complement arithmetic and an ACC_W-bit accumulator.
REQ-020 SHALL use exactly one multiplier, time-multiplexed over taps; per-channel history SHALL be held in a TAPS x CHANNELS register array.
REQ-021 FSM states: IDLE, MAC, OUT. IDLE->MAC on accept; MAC holds exactly TAPS cycles (tap counter 0..TAPS-1); MAC->OUT after the last tap; OUT->IDLE unconditionally.
REQ-022 x_ready SHALL be 1 only in IDLE with ena=1 and rst=0; accept = x_valid & x_ready at a rising edge.
REQ-023 On accept, the history of channel x_chan SHALL shift by one with x_in at position 0; other channels SHALL be untouched.
REQ-024 y_valid SHALL be high for exactly one cycle, asserted TAPS+2 rising edges after the accepting edge; y_out and y_chan SHALL hold until the next y_valid.
REQ-025 A new sample MAY be accepted in the same cycle y_valid is high; minimum spacing between accepts is TAPS+2 cycles.
REQ-026 Saturation: shifted result > 2^(N-1)-1 SHALL give 2^(N-1)-1; < -2^(N-1) SHALL give -2^(N-1); no wrap-around.
REQ-027 Accepted sample with x_chan >= CHANNELS SHALL be consumed (x_ready drops as normal), alter no history, and produce no y_valid.
REQ-028 coef_we SHALL write b[coef_addr] only when FSM is IDLE and ena=1; writes in MAC/OUT SHALL be ignored.
REQ-029 coef_we and accept in the same IDLE cycle: the coefficient write SHALL take effect before that sample's MAC.
REQ-030 ena=0 SHALL freeze FSM, counter, accumulator, history, coefficients and outputs; a pending y_valid SHALL be deferred, not lost or repeated.

Reset
REQ-031 rst=1 at a rising edge SHALL, regardless of state (including mid-MAC), force IDLE, clear counter, accumulator, all history and all coefficients to 0, and set y_out=0, y_chan=0, y_valid=0.
REQ-032 x_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts (ena=1); any in-flight result SHALL be discarded.

Verification (N=16, TAPS=4, CHANNELS=2, SHIFT=0 unless stated)
REQ-033 Load b={1,2,3,4}; ch0 impulse 101 then zeros -> ch0 y_out sequence 101, 202, 303, 404, 0; each y_valid exactly 6 edges after its accept.
REQ-034 Channel isolation: ch0 impulse 101 interleaved with ch1 constant 10 -> ch0 as REQ-033; ch1 ramps 10, 30, 60, 100, 100.
REQ-035 Saturation: b all 32767, ch0 x=32767 four times -> y_out=32767; x=-32768 four times -> y_out=-32768; SHIFT=16 variant with b={1,2,3,4}, x=65536-range stress checks arithmetic shift sign.
REQ-036 Reset mid-MAC: assert rst 2 cycles after accept -> no y_valid, all outputs 0, next impulse 101 with reloaded b={1,2,3,4} gives 101 (old history gone).
REQ-037 ena low for 5 cycles during MAC -> y_valid delayed by exactly 5 cycles, same value; coef_we during MAC ignored (read back via next impulse).
REQ-038 x_chan=3 accepted -> no y_valid, ch0/ch1 subsequent outputs unchanged.

Source files
------------

// File: rtl/fir_tdm.sv
// Time-multiplexed multi-channel FIR: one multiplier walks the taps of the
// accepted channel, then the saturated result is presented for one cycle.
module fir_tdm #(
    parameter  int N        = 16,
    parameter  int TAPS     = 8,
    parameter  int CHANNELS = 2,
    parameter  int SHIFT    = 0,
    localparam int AW       = $clog2(TAPS),
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                coef_we,
    input  logic [AW-1:0]       coef_addr,
    input  logic signed [N-1:0] coef_data,
    input  logic signed [N-1:0] x_in,
    input  logic [CW-1:0]       x_chan,
    input  logic                x_valid,
    output logic                x_ready,
    output logic signed [N-1:0] y_out,
    output logic [CW-1:0]       y_chan,
    output logic                y_valid
);
    localparam int ACC_W = 2*N + $clog2(TAPS);
    localparam int PW    = 2*N;
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                  state, state_nxt;
    logic [AW-1:0]           cnt;
    logic signed [ACC_W-1:0] acc, shifted;
    logic signed [N-1:0]     coef [TAPS];
    logic signed [N-1:0]     hist [CHANNELS][TAPS];
    logic [CW-1:0]           chan_q, chan_rd;
    logic                    chan_ok;
    logic                    res_vld;
    logic signed [PW-1:0]    prod;
    logic signed [N-1:0]     sat_val;
    logic                    accept;

    assign x_ready = (state == IDLE) && ena && !rst;
    assign accept  = x_valid && x_ready;

    // An out-of-range channel still runs the MAC; read a legal row instead.
    assign chan_rd = chan_ok ? chan_q : '0;
    assign prod    = PW'(coef[cnt]) * PW'(hist[chan_rd][cnt]);

    always_comb begin
        shifted = acc >>> SHIFT;
        sat_val = shifted[N-1:0];
        if (shifted > MAXV)
            sat_val = MAXV[N-1:0];
        else if (shifted < MINV)
            sat_val = MINV[N-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MAC;
            MAC:     if (cnt == AW'(TAPS-1)) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            chan_q  <= '0;
            chan_ok <= 1'b0;
            res_vld <= 1'b0;
            y_out   <= '0;
            y_chan  <= '0;
            y_valid <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= '0;
                for (int c = 0; c < CHANNELS; c++)
                    hist[c][k] <= '0;
            end
        end else if (ena) begin
            state <= state_nxt;
            // Write lands at the accept edge, so it is seen by that sample's first tap.
            if (coef_we && state == IDLE && int'(coef_addr) < TAPS)
                coef[coef_addr] <= coef_data;
            case (state)
                IDLE: if (accept) begin
                    cnt     <= '0;
                    acc     <= '0;
                    chan_q  <= x_chan;
                    chan_ok <= int'(x_chan) < CHANNELS;
                    if (int'(x_chan) < CHANNELS) begin
                        for (int k = TAPS-1; k > 0; k--)
                            hist[x_chan][k] <= hist[x_chan][k-1];
                        hist[x_chan][0] <= x_in;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    cnt <= (cnt == AW'(TAPS-1)) ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
            // Result is taken from acc one edge after OUT; acc/chan_q are only
            // overwritten by the next accept, which uses their old values here.
            res_vld <= (state == OUT) && chan_ok;
            y_valid <= res_vld;
            if (res_vld) begin
                y_out  <= sat_val;
                y_chan <= chan_q;
            end
        end
    end
endmodule

// File: tb/tb_fir_tdm.sv
// Randomized scoreboard bench for fir_tdm: two instances (SHIFT=0 and SHIFT=16)
// share stimulus and are compared against a sum-of-products reference.
module tb_fir_tdm;
    localparam int N = 16, TAPS = 4, CH = 3, CW = 2, AW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1, ena = 1'b1, coef_we = 1'b0, x_valid = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic signed [N-1:0] coef_data = '0, x_in = '0;
    logic [CW-1:0] x_chan = '0;
    logic x_ready0, x_ready1, yv0, yv1;
    logic signed [N-1:0] y0, y1;
    logic [CW-1:0] yc0, yc1;

    always #5 clk = ~clk;

    fir_tdm #(.N(N), .TAPS(TAPS), .CHANNELS(CH), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .ena(ena), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .x_in(x_in), .x_chan(x_chan), .x_valid(x_valid),
        .x_ready(x_ready0), .y_out(y0), .y_chan(yc0), .y_valid(yv0));

    fir_tdm #(.N(N), .TAPS(TAPS), .CHANNELS(CH), .SHIFT(16)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .x_in(x_in), .x_chan(x_chan), .x_valid(x_valid),
        .x_ready(x_ready1), .y_out(y1), .y_chan(yc1), .y_valid(yv1));

    typedef struct { int ch; int y; int due; } exp_t;
    exp_t q0[$], q1[$];
    int errors = 0, checks = 0;
    int ecnt = 0, busy_until = 0;
    int b_m[TAPS];
    int h_m[CH][TAPS];
    int last_y[2], last_c[2];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int fir_ref(int c, int sh);
        longint s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(b_m[k]) * longint'(h_m[c][k]);
        s = s >>> sh;
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return int'(s);
    endfunction

    // Enabled, non-reset edges are the design's time base.
    always @(posedge clk) if (ena && !rst) ecnt++;

    task automatic mon(int d, logic v, logic signed [N-1:0] y, logic [CW-1:0] c);
        exp_t e;
        if (v) begin
            if (ena) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    checks++; errors++;
                    $display("FAIL dut%0d unexpected y_valid: y=%0d ch=%0d", d, y, c);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("dut%0d y_out", d), int'(y), e.y);
                    chk($sformatf("dut%0d y_chan", d), int'(c), e.ch);
                    chk($sformatf("dut%0d latency", d), ecnt, e.due);
                end
                last_y[d] = int'(y);
                last_c[d] = int'(c);
            end
        end else begin
            chk($sformatf("dut%0d hold y_out", d), int'(y), last_y[d]);
            chk($sformatf("dut%0d hold y_chan", d), int'(c), last_c[d]);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit rdy;
        if (rst) begin
            chk("x_ready0 in reset", int'(x_ready0), 0);
            chk("x_ready1 in reset", int'(x_ready1), 0);
            q0.delete(); q1.delete();
            busy_until = 0;
            for (int k = 0; k < TAPS; k++) begin
                b_m[k] = 0;
                for (int c = 0; c < CH; c++) h_m[c][k] = 0;
            end
            last_y = '{0, 0};
            last_c = '{0, 0};
        end else begin
            mon(0, yv0, y0, yc0);
            mon(1, yv1, y1, yc1);
            rdy = ena && (ecnt >= busy_until);
            chk("x_ready0", int'(x_ready0), int'(rdy));
            chk("x_ready1", int'(x_ready1), int'(rdy));
            if (coef_we && rdy) b_m[coef_addr] = int'(coef_data);
            if (x_valid && rdy) begin
                busy_until = ecnt + TAPS + 2;
                if (int'(x_chan) < CH) begin
                    for (int k = TAPS-1; k > 0; k--) h_m[x_chan][k] = h_m[x_chan][k-1];
                    h_m[x_chan][0] = int'(x_in);
                    e.ch  = int'(x_chan);
                    e.due = ecnt + 1 + TAPS + 2;
                    e.y   = fir_ref(e.ch, 0);  q0.push_back(e);
                    e.y   = fir_ref(e.ch, 16); q1.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = x_ready0;
        end
        if (!ok) begin errors++; $display("FAIL wait_idle timeout"); end
        @(posedge clk); #1;
    endtask

    task automatic send(int c, int x);
        bit ok = 0;
        x_valid = 1; x_chan = CW'(c); x_in = N'(x);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = x_ready0;
        end
        if (!ok) begin errors++; $display("FAIL send timeout ch=%0d", c); end
        @(posedge clk); #1;
        x_valid = 0;
    endtask

    task automatic wcoef(int a, int v);
        coef_we = 1; coef_addr = AW'(a); coef_data = N'(v);
        tick();
        coef_we = 0;
    endtask

    task automatic load(int a0, int a1, int a2, int a3);
        wait_idle();
        wcoef(0, a0); wcoef(1, a1); wcoef(2, a2); wcoef(3, a3);
    endtask

    task automatic send_coef(int c, int x, int a, int v);
        wait_idle();
        coef_we = 1; coef_addr = AW'(a); coef_data = N'(v);
        send(c, x);
        coef_we = 0;
    endtask

    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = (q0.size() == 0) && (q1.size() == 0) && x_ready0;
        end
        if (!ok) begin errors++; $display("FAIL drain timeout q0=%0d q1=%0d", q0.size(), q1.size()); end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) tick();
        rst = 0;

        // impulse response, back-to-back accepts
        load(1, 2, 3, 4);
        send(0, 101);
        repeat (4) send(0, 0);
        drain();

        // channel isolation
        do_reset();
        load(1, 2, 3, 4);
        for (int i = 0; i < 5; i++) begin
            send(0, (i == 0) ? 101 : 0);
            send(1, 10);
        end
        drain();

        // saturation both directions, plus shifted instance
        load(32767, 32767, 32767, 32767);
        repeat (4) send(0, 32767);
        repeat (4) send(0, -32768);
        load(1, 2, 3, 4);
        repeat (4) send(2, -32768);
        repeat (4) send(2, 32767);
        drain();

        // reset mid-MAC discards the in-flight result and all history
        send(0, 55);
        tick(); tick();
        rst = 1; tick(); rst = 0;
        load(1, 2, 3, 4);
        send(0, 101);
        drain();

        // ena low during MAC, coefficient write during MAC ignored
        send(0, 77);
        tick();
        ena = 0; repeat (5) tick(); ena = 1;
        wcoef(0, 9);
        drain();
        send(0, 101);
        drain();

        // coefficient write in the same cycle as accept
        send_coef(1, 100, 0, -5);
        drain();

        // invalid channel consumed without output
        send(3, 1234);
        send(0, 5);
        send(1, 6);
        drain();

        for (int it = 0; it < 250; it++) begin
            int r = $urandom_range(0, 11);
            int full = $urandom_range(0, 1);
            int v = full ? $urandom_range(0, 65535) - 32768 : $urandom_range(0, 400) - 200;
            if (r <= 1) wcoef($urandom_range(0, TAPS-1), v);
            else if (r == 2) send_coef($urandom_range(0, 3), v, $urandom_range(0, TAPS-1),
                                       $urandom_range(0, 400) - 200);
            else if (r == 3) begin
                ena = 0; repeat ($urandom_range(1, 4)) tick(); ena = 1;
            end else if (r == 4) tick();
            else if (r == 5 && $urandom_range(0, 7) == 0) do_reset();
            else send($urandom_range(0, 3), v);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
